// File: rtl/mem_bus_pkg.sv
// Shared types for the I/D memory port arbiter: bus commands, owner sides,
// request bundle and the tag width used by the memory port.
package mem_bus_pkg;

  localparam int TAG_W = 4;
  localparam int NTAG  = 1 << TAG_W;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    bus_cmd_e    cmd;
    logic [63:0] addr;
    logic [63:0] data;
  } mem_req_t;

  function automatic mem_req_t req_idle();
    mem_req_t r;
    r.cmd  = BUS_NONE;
    r.addr = 64'd0;
    r.data = 64'd0;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and response signals of the arbiter. The arbiter uses the
// slave modport; the requesters/memory environment uses the master modport.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic [1:0]       i_req_cmd;
  logic [63:0]      i_req_addr;
  logic [63:0]      i_req_data;
  logic [TAG_W-1:0] i_req_tag;
  logic             i_rsp_valid;
  logic [TAG_W-1:0] i_rsp_tag;
  logic [63:0]      i_rsp_data;

  logic [1:0]       d_req_cmd;
  logic [63:0]      d_req_addr;
  logic [63:0]      d_req_data;
  logic [TAG_W-1:0] d_req_tag;
  logic             d_rsp_valid;
  logic [TAG_W-1:0] d_rsp_tag;
  logic [63:0]      d_rsp_data;

  logic [1:0]       proc2mem_command;
  logic [63:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  modport slave (
    input  i_req_cmd, i_req_addr, i_req_data,
    input  d_req_cmd, d_req_addr, d_req_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output i_req_tag, i_rsp_valid, i_rsp_tag, i_rsp_data,
    output d_req_tag, d_rsp_valid, d_rsp_tag, d_rsp_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport master (
    output i_req_cmd, i_req_addr, i_req_data,
    output d_req_cmd, d_req_addr, d_req_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  i_req_tag, i_rsp_valid, i_rsp_tag, i_rsp_data,
    input  d_req_tag, d_rsp_valid, d_rsp_tag, d_rsp_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data
  );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory tags: one valid bit and one side bit per
// tag. A free and an alloc on the same tag in one cycle leaves it allocated.
module mem_tag_table
  import mem_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_e           alloc_side,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output owner_e           lookup_side,
  output logic             alloc_busy
);

  logic [NTAG-1:0] valid_q, valid_d;
  logic [NTAG-1:0] side_q, side_d;

  // Next table contents: clear first, then set.
  always_comb begin
    valid_d = valid_q;
    side_d  = side_q;
    if (free_en) begin
      valid_d[free_tag] = 1'b0;
    end else begin
      valid_d[free_tag] = valid_q[free_tag];
    end
    if (alloc_en) begin
      valid_d[alloc_tag] = 1'b1;
      side_d[alloc_tag]  = alloc_side;
    end else begin
      side_d[alloc_tag]  = side_q[alloc_tag];
    end
  end

  // Lookup and collision status from the registered table.
  always_comb begin
    lookup_valid = (lookup_tag != {TAG_W{1'b0}}) && valid_q[lookup_tag];
    lookup_side  = owner_e'(side_q[lookup_tag]);
    alloc_busy   = valid_q[alloc_tag] && !(free_en && (free_tag == alloc_tag));
  end

  // Table state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {NTAG{1'b0}};
      side_q  <= {NTAG{1'b0}};
    end else begin
      valid_q <= valid_d;
      side_q  <= side_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between I and D requesters,
// with tag ownership tracking. Optional counters under MEM_ARB_PERF_EN.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int MAX_OUT = 8
`ifdef MEM_ARB_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus,
  output logic             arb_err
`ifdef MEM_ARB_PERF_EN
  , output logic [CNT_W-1:0] i_grant_cnt
  , output logic [CNT_W-1:0] d_grant_cnt
  , output logic [CNT_W-1:0] retry_cnt
  , output logic [CNT_W-1:0] i_stall_cnt
  , output logic [CNT_W-1:0] d_stall_cnt
`endif
);

  localparam int               CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_OUT);
  localparam logic [TAG_W-1:0] NO_TAG  = {TAG_W{1'b0}};

  mem_req_t         i_req_s, d_req_s, win_req_s;
  logic             i_elig_s, d_elig_s, grant_i_s, grant_d_s, accept_s;
  logic             alloc_en_s, free_en_s, lookup_valid_s, alloc_busy_s, drop_s;
  logic             i_stall_s, d_stall_s;
  logic             i_rsp_s, d_rsp_s;
  owner_e           win_side_s, lookup_side_s;
  owner_e           last_grant_q, last_grant_d;
  logic [CW-1:0]    i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic             arb_err_q, arb_err_d;

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CW-1:0] r;
    if (inc && !dec && (cnt < MAX_CNT)) begin
      r = cnt + CW'(1'b1);
    end else if (dec && !inc && (cnt != {CW{1'b0}})) begin
      r = cnt - CW'(1'b1);
    end else begin
      r = cnt;
    end
    return r;
  endfunction

  // Eligibility and round-robin winner selection.
  always_comb begin
    i_req_s   = '{cmd: bus_cmd_e'(bus.i_req_cmd), addr: bus.i_req_addr, data: bus.i_req_data};
    d_req_s   = '{cmd: bus_cmd_e'(bus.d_req_cmd), addr: bus.d_req_addr, data: bus.d_req_data};
    i_stall_s = (i_req_s.cmd == BUS_LOAD) && !(i_cnt_q < MAX_CNT);
    d_stall_s = (d_req_s.cmd == BUS_LOAD) && !(d_cnt_q < MAX_CNT);
    i_elig_s  = (i_req_s.cmd != BUS_NONE) && !i_stall_s;
    d_elig_s  = (d_req_s.cmd != BUS_NONE) && !d_stall_s;
    grant_i_s = i_elig_s && (!d_elig_s || (last_grant_q == OWN_D));
    grant_d_s = d_elig_s && !grant_i_s;
    win_side_s = grant_d_s ? OWN_D : OWN_I;
    if (grant_i_s) begin
      win_req_s = i_req_s;
    end else if (grant_d_s) begin
      win_req_s = d_req_s;
    end else begin
      win_req_s = req_idle();
    end
    accept_s   = (grant_i_s || grant_d_s) && (bus.mem2proc_response != NO_TAG);
    alloc_en_s = accept_s && (win_req_s.cmd == BUS_LOAD);
    // A nonzero return tag with no owner is dropped and flagged.
    free_en_s  = lookup_valid_s;
    drop_s     = (bus.mem2proc_tag != NO_TAG) && !lookup_valid_s;
    i_rsp_s    = free_en_s && (lookup_side_s == OWN_I);
    d_rsp_s    = free_en_s && (lookup_side_s == OWN_D);
  end

  // Memory command, requester acks and returned data routing.
  always_comb begin
    bus.proc2mem_command = win_req_s.cmd;
    bus.proc2mem_addr    = win_req_s.addr;
    bus.proc2mem_data    = win_req_s.data;
    bus.i_req_tag        = grant_i_s ? bus.mem2proc_response : NO_TAG;
    bus.d_req_tag        = grant_d_s ? bus.mem2proc_response : NO_TAG;
    bus.i_rsp_valid      = i_rsp_s;
    bus.i_rsp_tag        = i_rsp_s ? bus.mem2proc_tag : NO_TAG;
    bus.i_rsp_data       = i_rsp_s ? bus.mem2proc_data : 64'd0;
    bus.d_rsp_valid      = d_rsp_s;
    bus.d_rsp_tag        = d_rsp_s ? bus.mem2proc_tag : NO_TAG;
    bus.d_rsp_data       = d_rsp_s ? bus.mem2proc_data : 64'd0;
  end

  mem_tag_table u_tag_table (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en_s),
    .alloc_tag    (bus.mem2proc_response),
    .alloc_side   (win_side_s),
    .free_en      (free_en_s),
    .free_tag     (bus.mem2proc_tag),
    .lookup_tag   (bus.mem2proc_tag),
    .lookup_valid (lookup_valid_s),
    .lookup_side  (lookup_side_s),
    .alloc_busy   (alloc_busy_s)
  );

  // Next-state for grant history, outstanding counts and the error flag.
  always_comb begin
    last_grant_d = accept_s ? win_side_s : last_grant_q;
    i_cnt_d   = next_cnt(i_cnt_q, alloc_en_s && (win_side_s == OWN_I), i_rsp_s);
    d_cnt_d   = next_cnt(d_cnt_q, alloc_en_s && (win_side_s == OWN_D), d_rsp_s);
    arb_err_d = arb_err_q || drop_s || (alloc_en_s && alloc_busy_s);
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_D;
      i_cnt_q      <= {CW{1'b0}};
      d_cnt_q      <= {CW{1'b0}};
      arb_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      i_cnt_q      <= i_cnt_d;
      d_cnt_q      <= d_cnt_d;
      arb_err_q    <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] i_grant_q, i_grant_d, d_grant_q, d_grant_d, retry_q, retry_d;
  logic [CNT_W-1:0] i_stall_q, i_stall_d, d_stall_q, d_stall_d;

  // Performance counter increments; all wrap naturally.
  always_comb begin
    i_grant_d = i_grant_q + CNT_W'(accept_s && grant_i_s);
    d_grant_d = d_grant_q + CNT_W'(accept_s && grant_d_s);
    retry_d   = retry_q + CNT_W'((grant_i_s || grant_d_s) && !accept_s);
    i_stall_d = i_stall_q + CNT_W'(i_stall_s);
    d_stall_d = d_stall_q + CNT_W'(d_stall_s);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grant_q <= {CNT_W{1'b0}};
      d_grant_q <= {CNT_W{1'b0}};
      retry_q   <= {CNT_W{1'b0}};
      i_stall_q <= {CNT_W{1'b0}};
      d_stall_q <= {CNT_W{1'b0}};
    end else begin
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      retry_q   <= retry_d;
      i_stall_q <= i_stall_d;
      d_stall_q <= d_stall_d;
    end
  end

  assign i_grant_cnt = i_grant_q;
  assign d_grant_cnt = d_grant_q;
  assign retry_cnt   = retry_q;
  assign i_stall_cnt = i_stall_q;
  assign d_stall_cnt = d_stall_q;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core-to-memory port between two requesters: instruction side (I, icache/fetch controller) and data side (D, dcache/LSQ).
- Arbitrates requests each cycle and forwards the winner combinationally to the memory command/address/data bus.
- Records which requester owns each outstanding memory tag and routes returned load data back to that owner.
- Sits between the two cache controllers and the main memory model inside the core.

Parameters:
- TAG_W, 4, width of memory tags; tag 0 means "no tag / rejected".
- MAX_OUT, 8, maximum outstanding loads per requester (1..2^TAG_W-1).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req_cmd  in  2  I-side command: 0 NONE, 1 LOAD, 2 STORE
- i_req_addr  in  64  I-side address
- i_req_data  in  64  I-side store data
- i_req_tag  out  TAG_W  tag accepted this cycle for I; 0 means not accepted
- i_rsp_valid  out  1  returned data for I this cycle
- i_rsp_tag  out  TAG_W  tag of returned I data
- i_rsp_data  out  64  returned I data
- d_req_cmd, d_req_addr, d_req_data, d_req_tag, d_rsp_valid, d_rsp_tag, d_rsp_data: same as I-side, for D
- proc2mem_command  out  2  to memory
- proc2mem_addr  out  64  to memory
- proc2mem_data  out  64  to memory
- mem2proc_response  in  TAG_W  acceptance tag, 0 = rejected
- mem2proc_data  in  64  returned data
- mem2proc_tag  in  TAG_W  tag of returned data, 0 = none
- arb_err  out  1  sticky: a nonzero tag returned with no owner, or a load was accepted onto an already-valid tag

Behaviour:
- Reset: last_grant=D; owner table invalid; both outstanding counts 0; arb_err=0; all *_req_tag and *_rsp_valid are 0.
- Eligibility: a side is eligible when cmd != NONE, and for a LOAD its outstanding count < MAX_OUT. STORE is always eligible.
- Arbitration is round-robin.
  - One eligible side wins.
  - If both are eligible, the side opposite last_grant wins.
  - last_grant updates only when the memory accepts (mem2proc_response != 0).
  - A rejected grant leaves last_grant unchanged, so the same winner retries next cycle.
- Forwarding is purely combinational, with zero latency.
  - proc2mem_* mirror the winner's cmd/addr/data.
  - With no winner, proc2mem_command = NONE and addr/data = 0.
- Acknowledge: winner's *_req_tag = mem2proc_response, combinationally in the same cycle. The loser's tag is 0. Requesters hold cmd/addr/data until they see a nonzero tag.
- On an accepted LOAD, at the clock edge:
  - owner[tag] becomes valid with the winning side.
  - That side's count increments.
- Accepted STORE: no table entry, no count change.
- Return path:
  - When mem2proc_tag != 0 and owner[tag] is valid, assert the owner's *_rsp_valid combinationally with rsp_tag=mem2proc_tag and rsp_data=mem2proc_data.
  - At the edge, clear the entry and decrement the owner's count.
  - If the entry is invalid, drop the return and set arb_err.
- Simultaneous return and accept on the same tag: the clear applies first, then the set, so the entry ends valid with the new owner.
- Counts: increment and decrement in the same cycle on the same side leave the count unchanged. Counts never exceed MAX_OUT and never go below 0.
- Reset mid-operation: all state clears immediately. Data returning later for pre-reset tags is dropped and sets arb_err; benches reset memory together with the arbiter.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, add the following CNT_W-bit output counters, wrapping at 2^CNT_W and cleared by rst:
  - i_grant_cnt and d_grant_cnt, counting accepted requests.
  - retry_cnt, counting cycles where a winner existed but the response was 0.
  - i_stall_cnt and d_stall_cnt, counting cycles where a LOAD was blocked by MAX_OUT.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_bus_pkg holds:
  - BUS_NONE, BUS_LOAD and BUS_STORE as a 2-bit enum.
  - TAG_W.
  - typedef owner_e {OWN_I, OWN_D}.
  - mem_req_t struct {cmd, addr, data}.
- One sub-module, mem_tag_table, holds the 2^TAG_W owner valid/side entries.
  - It provides alloc and free ports and a lookup output.
  - It implements the clear-then-set ordering.

Test Plan:
- Only I issues LOAD 0x100; memory responds with tag 3 → i_req_tag=3 that cycle, I count=1. Later mem2proc_tag=3 with data 0xDEAD → i_rsp_valid=1, i_rsp_data=0xDEAD, I count=0, d_rsp_valid=0.
- I and D both LOAD for 4 cycles, memory accepts every cycle → grants alternate I,D,I,D after reset (last_grant=D, so I goes first).
- Both request, and memory rejects (response 0) for 2 cycles → the same winner stays on the bus and last_grant does not change. On the 3rd cycle the response is 5, that winner is acked, and the other side wins next.
- MAX_OUT=2: D issues 3 LOADs with no returns → third held: proc2mem_command=NONE unless I requests; d_req_tag=0. After one return, the third is accepted.
- Tag 7 returns in the same cycle a new D LOAD is accepted with tag 7 → the old owner (I) gets the data; owner[7]=D afterward; counts stay consistent.
- mem2proc_tag=9 with no outstanding tag 9 → no rsp_valid on either side; arb_err=1 and it stays set until rst.
